// File: rtl/serial_frame_transmitter.sv
// ---------------------------------------------------------------------------
// serial_frame_transmitter
//   Queues parallel words in a small FIFO and sends each one as a framed
//   synchronous serial burst: a frame strobe (transmission), a generated bit
//   clock (transmission_clock, receiver samples on its rising edge) and a data
//   line (out_data). Width, bit rate, bit order and even parity are set by
//   parameters.
//
// Ports
//   clk                 in   system clock, all logic on posedge
//   rst                 in   asynchronous, active-high reset
//   send                in   push request, sampled on each posedge
//   in_data             in   word pushed when send && ready
//   ready               out  FIFO not full
//   overflow            out  one-cycle pulse: send while !ready, word dropped
//   transmission        out  high for the whole frame
//   transmission_clock  out  bit clock
//   out_data            out  serial data bit
//   busy                out  FSM not idle, or FIFO non-empty
// ---------------------------------------------------------------------------
module serial_frame_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_EN  = 1'b0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  ready,
  output logic                  overflow,
  output logic                  transmission,
  output logic                  transmission_clock,
  output logic                  out_data,
  output logic                  busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_PARITY, S_GAP} state_t;

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;
  state_t                state, state_next;

  // ready is already low when full, so a same-edge pop cannot rescue a push.
  assign push = send && ready;
  assign pop  = (state == S_IDLE) && (count != '0);
  assign head = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      ready    <= (count_next < CNT_FULL);
      overflow <= send && !ready;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count alone,
  // which keeps the array mappable to plain RAM/registers without reset nets.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0]      div, div_next;
  logic [BIT_W-1:0]      bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic                  parity_bit, parity_next;
  logic                  tx_next, tclk_next, dout_next, busy_next;

  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      div                <= '0;
      bit_cnt            <= '0;
      shreg              <= '0;
      parity_bit         <= 1'b0;
      transmission       <= 1'b0;
      transmission_clock <= 1'b0;
      out_data           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= state_next;
      div                <= div_next;
      bit_cnt            <= bit_next;
      shreg              <= shreg_next;
      parity_bit         <= parity_next;
      transmission       <= tx_next;
      transmission_clock <= tclk_next;
      out_data           <= dout_next;
      busy               <= busy_next;
    end
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_next  = state;
    div_next    = div;
    bit_next    = bit_cnt;
    shreg_next  = shreg;
    parity_next = parity_bit;
    tx_next     = transmission;
    tclk_next   = transmission_clock;
    dout_next   = out_data;

    case (state)
      S_IDLE: begin
        if (count != '0) begin
          // The word is copied out, so later pushes cannot touch it.
          shreg_next  = head;
          parity_next = ^head;
          state_next  = S_LOAD;
        end
      end

      S_LOAD: begin
        state_next = S_SHIFT;
        tx_next    = 1'b1;
        tclk_next  = 1'b0;
        dout_next  = lead_bit(shreg);
        bit_next   = '0;
        div_next   = '0;
      end

      S_SHIFT, S_PARITY: begin
        if (div == DIV_LAST) begin
          div_next  = '0;
          tclk_next = 1'b0;
          if (state == S_SHIFT && bit_cnt != BIT_LAST) begin
            bit_next   = bit_cnt + BIT_W'(1);
            shreg_next = shift_word(shreg);
            dout_next  = lead_bit(shift_word(shreg));
          end else if (state == S_SHIFT && PARITY_EN) begin
            state_next = S_PARITY;
            dout_next  = parity_bit;
          end else begin
            state_next = S_GAP;
            tx_next    = 1'b0;
            dout_next  = 1'b0;
          end
        end else begin
          div_next  = div + DIV_W'(1);
          // Registered one cycle ahead: high for the last CLK_DIV cycles.
          tclk_next = (div >= DIV_HALF);
        end
      end

      S_GAP: begin
        tx_next   = 1'b0;
        tclk_next = 1'b0;
        dout_next = 1'b0;
        if (div == DIV_LAST) begin
          div_next   = '0;
          state_next = S_IDLE;
        end else begin
          div_next = div + DIV_W'(1);
        end
      end

      default: state_next = S_IDLE;
    endcase

    busy_next = (state_next != S_IDLE) || (count_next != '0);
  end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_transmitter
//   Three transmitter instances with different parameter sets share clk/rst:
//     d=0 : defaults (8 bit, CLK_DIV 4, MSB first, no parity)
//     d=1 : 8 bit, CLK_DIV 4, LSB first, even parity
//     d=2 : 16 bit, CLK_DIV 1, MSB first, no parity
//   A receiver task decodes frames from the pins; expected bit streams, frame
//   lengths and gaps are computed from the word and the parameter set.
// ---------------------------------------------------------------------------
module tb_serial_frame_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  send;
  logic [7:0]  din_a, din_b;
  logic [15:0] din_c;
  logic [2:0]  rdy, ovf, tx, tclk, dout, bsy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_frame_transmitter dut_a (
    .clk(clk), .rst(rst), .send(send[0]), .in_data(din_a), .ready(rdy[0]),
    .overflow(ovf[0]), .transmission(tx[0]), .transmission_clock(tclk[0]),
    .out_data(dout[0]), .busy(bsy[0]));

  serial_frame_transmitter #(.DATA_WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b0),
                             .PARITY_EN(1'b1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .send(send[1]), .in_data(din_b), .ready(rdy[1]),
    .overflow(ovf[1]), .transmission(tx[1]), .transmission_clock(tclk[1]),
    .out_data(dout[1]), .busy(bsy[1]));

  serial_frame_transmitter #(.DATA_WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b1),
                             .PARITY_EN(1'b0), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .send(send[2]), .in_data(din_c), .ready(rdy[2]),
    .overflow(ovf[2]), .transmission(tx[2]), .transmission_clock(tclk[2]),
    .out_data(dout[2]), .busy(bsy[2]));

  // Parameter set of each instance.
  function automatic int p_w(input int d);   return (d == 2) ? 16 : 8; endfunction
  function automatic int p_div(input int d); return (d == 2) ? 1 : 4;  endfunction
  function automatic int p_msb(input int d); return (d == 1) ? 0 : 1;  endfunction
  function automatic int p_par(input int d); return (d == 1) ? 1 : 0;  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Reference: the bit stream in transmit order, bit i = i-th bit on the wire.
  function automatic logic [63:0] ref_bits(input int d, input logic [31:0] word);
    logic [63:0] r;
    int ones;
    int w;
    r    = '0;
    ones = 0;
    w    = p_w(d);
    for (int i = 0; i < w; i++) begin
      int idx;
      idx  = (p_msb(d) != 0) ? (w - 1 - i) : i;
      r[i] = word[idx];
      ones += int'(word[i]);
    end
    if (p_par(d) != 0) r[w] = (ones % 2) == 1;
    return r;
  endfunction

  task automatic set_word(input int d, input logic [31:0] word);
    case (d)
      0:       din_a = word[7:0];
      1:       din_b = word[7:0];
      default: din_c = word[15:0];
    endcase
  endtask

  // One send pulse sampled on a single posedge; returns at the next negedge.
  task automatic push(input int d, input logic [31:0] word);
    @(negedge clk);
    set_word(d, word);
    send[d] = 1'b1;
    @(negedge clk);
    send[d] = 1'b0;
  endtask

  // Decode one frame. lead = low samples before the frame, len = high samples,
  // hi = samples with the bit clock high, clean = pins quiet while idle/gap.
  task automatic recv(input int d, output logic [63:0] bits, output int nb,
                      output int len, output int lead, output int hi, output bit clean);
    bit pt;
    bits = '0; nb = 0; len = 0; lead = 0; hi = 0; clean = 1'b1; pt = 1'b0;
    while (1) begin
      @(negedge clk);
      if (tx[d]) break;
      if (tclk[d] || dout[d]) clean = 1'b0;
      lead++;
      if (lead > 3000) begin
        check("rx_start_timeout", {63'd0, tx[d]}, 64'd1);
        return;
      end
    end
    while (tx[d] && len < 4000) begin
      len++;
      if (tclk[d]) hi++;
      if (tclk[d] && !pt && nb < 64) begin
        bits[nb] = dout[d];
        nb++;
      end
      pt = tclk[d];
      @(negedge clk);
    end
    if (tclk[d] || dout[d]) clean = 1'b0;
  endtask

  task automatic check_frame(input int d, input logic [31:0] word, input logic [63:0] bits,
                             input int nb, input int len, input int hi, input bit clean);
    int nbits;
    nbits = p_w(d) + p_par(d);
    check($sformatf("d%0d_bits_%0h", d, word), bits, ref_bits(d, word));
    check($sformatf("d%0d_nbits", d), 64'(nb), 64'(nbits));
    check($sformatf("d%0d_len", d), 64'(len), 64'(nbits * 2 * p_div(d)));
    check($sformatf("d%0d_clk_high", d), 64'(hi), 64'(nbits * p_div(d)));
    check($sformatf("d%0d_quiet", d), {63'd0, clean}, 64'd1);
  endtask

  task automatic wait_idle(input int d);
    int g;
    g = 0;
    @(negedge clk);
    while (bsy[d] && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check($sformatf("d%0d_idle", d), {63'd0, bsy[d]}, 64'd0);
  endtask

  task automatic run_random(input int d, input int n);
    logic [31:0] q[$];
    logic [31:0] mask;
    mask = (p_w(d) == 32) ? 32'hFFFF_FFFF : ((32'd1 << p_w(d)) - 32'd1);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          logic [31:0] w;
          int g;
          w = $urandom & mask;
          repeat ($urandom_range(0, 12)) @(negedge clk);
          @(negedge clk);
          g = 0;
          while (!rdy[d] && g < 3000) begin
            @(negedge clk);
            g++;
          end
          set_word(d, w);
          send[d] = 1'b1;
          q.push_back(w);
          @(negedge clk);
          send[d] = 1'b0;
        end
      end
      begin
        for (int i = 0; i < n; i++) begin
          logic [63:0] bits;
          int nb, len, lead, hi;
          bit clean;
          recv(d, bits, nb, len, lead, hi, clean);
          if (q.size() == 0) begin
            check($sformatf("d%0d_rand_unexpected_frame", d), 64'd1, 64'd0);
          end else begin
            check_frame(d, q.pop_front(), bits, nb, len, hi, clean);
          end
        end
      end
    join
  endtask

  initial begin
    logic [63:0] bits;
    int nb, len, lead, hi, cnt;
    bit clean;
    logic [7:0] w3 [6];

    rst = 1'b1; send = '0; din_a = '0; din_b = '0; din_c = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d_reset_pins", d),
            {58'd0, rdy[d], ovf[d], tx[d], tclk[d], dout[d], bsy[d]}, 64'b100000);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_pins", {58'd0, rdy[0], ovf[0], tx[0], tclk[0], dout[0], bsy[0]}, 64'b100000);

    // Single word, defaults: frame starts two edges after the push edge.
    push(0, 32'hA5);
    recv(0, bits, nb, len, lead, hi, clean);
    check("d0_latency", 64'(lead), 64'd1);
    check_frame(0, 32'hA5, bits, nb, len, hi, clean);
    wait_idle(0);

    // LSB first with parity.
    push(1, 32'h07);
    recv(1, bits, nb, len, lead, hi, clean);
    check_frame(1, 32'h07, bits, nb, len, hi, clean);
    wait_idle(1);

    // 16-bit word at the fastest bit clock.
    push(2, 32'h8001);
    recv(2, bits, nb, len, lead, hi, clean);
    check_frame(2, 32'h8001, bits, nb, len, hi, clean);
    wait_idle(2);

    // Six pushes on consecutive edges while idle: five accepted, one overflow.
    for (int i = 0; i < 6; i++) w3[i] = 8'($urandom);
    cnt = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (k > 0 && ovf[0]) cnt++;
          if (k == 4) check("burst_ready_before_full", {63'd0, rdy[0]}, 64'd1);
          if (k == 5) check("burst_ready_full", {63'd0, rdy[0]}, 64'd0);
          if (k == 6) check("burst_overflow", {63'd0, ovf[0]}, 64'd1);
          send[0] = (k < 6);
          din_a   = w3[k % 6];
        end
        check("burst_overflow_pulses", 64'(cnt), 64'd1);
      end
      begin
        recv(0, bits, nb, len, lead, hi, clean);
        check_frame(0, 32'(w3[0]), bits, nb, len, hi, clean);
      end
    join

    // Full FIFO: send on the idle-pop edge is rejected while the pop happens.
    repeat (2 * p_div(0)) @(posedge clk);
    @(negedge clk);
    din_a   = 8'h3C;
    send[0] = 1'b1;
    @(negedge clk);
    send[0] = 1'b0;
    check("pop_edge_overflow", {63'd0, ovf[0]}, 64'd1);
    check("pop_edge_ready", {63'd0, rdy[0]}, 64'd1);
    check("pop_edge_busy", {63'd0, bsy[0]}, 64'd1);

    for (int i = 1; i < 5; i++) begin
      recv(0, bits, nb, len, lead, hi, clean);
      if (i > 1) check($sformatf("gap_%0d", i), 64'(lead), 64'(2 * p_div(0) + 1));
      check_frame(0, 32'(w3[i]), bits, nb, len, hi, clean);
    end
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx[0]) cnt++;
    end
    check("dropped_word_not_sent", 64'(cnt), 64'd0);
    wait_idle(0);

    // Reset during bit 3 of a frame with a full queue behind it.
    for (int i = 0; i < 5; i++) push(0, 32'h10 + 32'(i));
    check("pre_reset_full", {63'd0, rdy[0]}, 64'd0);
    cnt = 0;
    begin
      bit pt;
      int g;
      pt = tclk[0];
      g  = 0;
      while (cnt < 3 && g < 3000) begin
        @(negedge clk);
        if (tclk[0] && !pt) cnt++;
        pt = tclk[0];
        g++;
      end
    end
    check("reached_bit3", 64'(cnt), 64'd3);
    repeat (p_div(0) + 1) @(negedge clk);
    check("mid_frame_tx", {63'd0, tx[0]}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_pins", {58'd0, rdy[0], ovf[0], tx[0], tclk[0], dout[0], bsy[0]}, 64'b100000);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx[0] || bsy[0]) cnt++;
    end
    check("queue_discarded", 64'(cnt), 64'd0);
    push(0, 32'hC3);
    recv(0, bits, nb, len, lead, hi, clean);
    check("post_reset_latency", 64'(lead), 64'd1);
    check_frame(0, 32'hC3, bits, nb, len, hi, clean);
    wait_idle(0);

    // Randomized traffic with handshake on every parameter set.
    run_random(0, 6);
    run_random(1, 8);
    run_random(2, 8);
    for (int d = 0; d < 3; d++) wait_idle(d);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
